btn_debouncer: RTL
==================

Name: btn_debouncer

Overview:
Input conditioning stage directly upstream of the block-position/colour controller. It takes four raw, bouncy, asynchronous direction push-buttons (up, down, left, right) and produces clean, clk-synchronous outputs for the controller's up/down/left/right inputs. Each button gets two outputs: a debounced level for continuous motion and a single-cycle press pulse for one-step moves. All four channels are independent and identical.

Parameters:
DEB_CYCLES, 500000, clk cycles an input must stay stable before a press or release is accepted (5 ms at 100 MHz); minimum 2.
REPEAT_DELAY, 50000000, cycles of continuous hold before the first auto-repeat pulse (used only with BTN_REPEAT_EN).
REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeat pulses (used only with BTN_REPEAT_EN).

Ports:
clk  input  1  system clock; the only clock.
rst  input  1  asynchronous, active-high reset.
btn_raw  input  4  raw buttons {up, down, left, right} = bits [3:0]; asynchronous, active-high.
btn_level  output  4  debounced level per button, same bit order.
btn_pulse  output  4  one-clk-wide press pulse per button, same bit order.

Behaviour:
- Reset (async assert, any state): both synchronizer flops = 0, FSM = IDLE, all counters = 0, btn_level = 0, btn_pulse = 0.
- Synchronizer: 2-flop per bit. s = second flop. The FSM uses only s.
- Per-channel FSM, with a debounce counter of width $clog2(DEB_CYCLES):
  - IDLE: if s=1, go to WAIT_PRESS with cnt=0.
  - WAIT_PRESS: if s=0, go to IDLE (bounce rejected, no output). Otherwise cnt++. When cnt==DEB_CYCLES-1, go to HELD, set level=1, and pulse=1 for exactly one cycle.
  - HELD: level=1. If s=0, go to WAIT_RELEASE with cnt=0.
  - WAIT_RELEASE: level remains 1. If s=1, go back to HELD (no new pulse). Otherwise cnt++. When cnt==DEB_CYCLES-1, go to IDLE with level=0.
- Latency: let N0 be the first edge that samples raw high, with raw stable afterwards. btn_level rises and btn_pulse is asserted at edge N0+DEB_CYCLES+2. Release is symmetric: btn_level falls DEB_CYCLES+2 edges after raw goes low.
- All outputs are registered. Pulses never exceed one cycle, and there is exactly one pulse per accepted press.
- Simultaneous presses: channels are fully independent, and several btn_pulse bits may assert in the same cycle. No priority is applied here; the consumer arbitrates.
- A button held through reset deassertion is treated as a fresh press: pulse at DEB_CYCLES+2 edges after reset release.
- Reset mid-debounce aborts the pending press/release with no pulse.
- Counters saturate by state exit and never wrap.

Optional Feature:
Macro BTN_REPEAT_EN.
- Defined: each channel adds a repeat counter of width $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)), cleared on entry to HELD and counting only while in HELD.
  - After the press pulse, an extra one-cycle pulse fires REPEAT_DELAY cycles later, then every REPEAT_PERIOD cycles while the channel stays in HELD.
  - Going to WAIT_RELEASE freezes the repeat counter. Returning to HELD from WAIT_RELEASE clears it, so the full REPEAT_DELAY applies again.
- Undefined: no repeat logic and exactly one pulse per press.

Decomposition:
- Shared package btn_pkg: FSM state encoding (IDLE=2'd0, WAIT_PRESS=2'd1, HELD=2'd2, WAIT_RELEASE=2'd3) and button index constants (BTN_RIGHT=0, BTN_LEFT=1, BTN_DOWN=2, BTN_UP=3).
- One sub-module, debounce_channel: one synchronizer, one FSM and the optional repeat logic, with 1-bit raw/level/pulse. btn_debouncer instantiates it 4 times via generate.

Test Plan:
Use DEB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
1. Clean press: btn_raw[0] rises before edge 0 and is held -> btn_level[0] and btn_pulse[0] go high at edge 6; pulse is low at edge 7; other bits stay 0.
2. Bounce reject: btn_raw[2] toggles 1,1,0,1,1,1,0 at one value per cycle -> btn_level and btn_pulse stay 0 throughout.
3. Release glitch: while held, btn_raw[1] goes low for 2 cycles then high -> btn_level[1] stays 1 and there is no second pulse. A later sustained low gives btn_level[1]=0 exactly 6 edges after it starts.
4. Simultaneous press: btn_raw=4'b1001 on the same edge -> btn_pulse=4'b1001 in a single cycle at edge 6.
5. Reset mid-operation: assert rst 3 cycles into WAIT_PRESS with raw still high -> outputs 0 immediately (async). After release, a pulse occurs 6 edges after the first post-reset sample.
6. With BTN_REPEAT_EN, hold btn_raw[3] -> pulses at edges 6, 16, 19 and 22. Without the macro, only the pulse at edge 6.

Source files
------------

// File: rtl/btn_debouncer_pkg.sv
// Shared definitions for the direction-button debouncer: per-channel FSM
// encoding, button bit positions and a small elaboration helper.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    HELD         = 2'd2,
    WAIT_RELEASE = 2'd3
  } btn_state_t;

  localparam int BTN_RIGHT = 0;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_UP    = 3;
  localparam int NUM_BTN   = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debouncer_if.sv
// Button bundle between the raw pads and the block controller.
// btn_raw is asynchronous; btn_level/btn_pulse/dbg_state are clk-synchronous and registered.
interface btn_debouncer_if;

  logic [btn_pkg::NUM_BTN-1:0]   btn_raw;
  logic [btn_pkg::NUM_BTN-1:0]   btn_level;
  logic [btn_pkg::NUM_BTN-1:0]   btn_pulse;
  // Two bits of FSM state per channel, channel g at [2g+1:2g].
  logic [2*btn_pkg::NUM_BTN-1:0] dbg_state;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_pulse,
    input  dbg_state
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_pulse,
    output dbg_state
  );

endinterface

// File: rtl/btn_debouncer_channel.sv
// One debounced button: 2-flop synchronizer, press/release FSM and, when
// BTN_REPEAT_EN is defined, an auto-repeat pulse generator while held.
module debounce_channel
  import btn_pkg::*;
#(
  parameter int DEB_CYCLES    = 500000
`ifdef BTN_REPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_raw,
  output logic       o_level,
  output logic       o_pulse,
  output btn_state_t o_state
);

  localparam int             CW      = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEB_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  btn_state_t    r_state;
  btn_state_t    w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_level;
  logic          r_pulse;
  logic          w_level_nxt;
  logic          w_press;
  logic          w_pulse_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_press     = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_sync2) begin
          w_state_nxt = WAIT_PRESS;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_PRESS: begin
        if (!r_sync2) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt = HELD;
          w_press     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      HELD: begin
        if (!r_sync2) begin
          w_state_nxt = WAIT_RELEASE;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_RELEASE: begin
        // A short dropout returns to HELD silently; only a stable low releases.
        if (r_sync2) begin
          w_state_nxt = HELD;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    w_level_nxt = (w_state_nxt == HELD) || (w_state_nxt == WAIT_RELEASE);
  end

`ifdef BTN_REPEAT_EN
  localparam int            RMAX      = max_int(REPEAT_DELAY, REPEAT_PERIOD);
  localparam int            RW        = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RW-1:0] RDLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPER_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] r_rcnt;
  logic [RW-1:0] w_rcnt_nxt;
  logic          r_rfirst;
  logic          w_rfirst_nxt;
  logic          w_repeat;

  always_comb begin
    w_rcnt_nxt   = r_rcnt;
    w_rfirst_nxt = r_rfirst;
    w_repeat     = 1'b0;
    if ((w_state_nxt == HELD) && (r_state != HELD)) begin
      w_rcnt_nxt   = '0;
      w_rfirst_nxt = 1'b1;
    end else if ((w_state_nxt == HELD) && (r_state == HELD)) begin
      // First interval is the long delay, later ones the short period.
      if (r_rcnt == (r_rfirst ? RDLY_LAST : RPER_LAST)) begin
        w_repeat     = 1'b1;
        w_rcnt_nxt   = '0;
        w_rfirst_nxt = 1'b0;
      end else begin
        w_rcnt_nxt = r_rcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rcnt   <= '0;
      r_rfirst <= 1'b1;
    end else begin
      r_rcnt   <= w_rcnt_nxt;
      r_rfirst <= w_rfirst_nxt;
    end
  end

  assign w_pulse_nxt = w_press | w_repeat;
`else
  assign w_pulse_nxt = w_press;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_state <= IDLE;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
      r_pulse <= w_pulse_nxt;
    end
  end

  assign o_level = r_level;
  assign o_pulse = r_pulse;
  assign o_state = r_state;

endmodule

// File: rtl/btn_debouncer.sv
// Four independent debounced direction buttons {up, down, left, right}.
// Auto-repeat is compiled in when BTN_REPEAT_EN is defined.
module btn_debouncer
  import btn_pkg::*;
#(
  parameter int DEB_CYCLES    = 500000
`ifdef BTN_REPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
`endif
) (
  input logic             clk,
  input logic             rst,
  btn_debouncer_if.slave  bus
);

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    btn_state_t w_state;

    debounce_channel #(
      .DEB_CYCLES    (DEB_CYCLES)
`ifdef BTN_REPEAT_EN
      ,
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .i_raw   (bus.btn_raw[g]),
      .o_level (bus.btn_level[g]),
      .o_pulse (bus.btn_pulse[g]),
      .o_state (w_state)
    );

    assign bus.dbg_state[2*g +: 2] = w_state;
  end

endmodule
